ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack for the 8-bit core. It is the downward counterpart of the PC +4 incrementer.
- Each push decrements the stack pointer by 4 and stores an 8-bit address; each pop returns the top entry and increments the pointer by 4.
- Sits beside the PC datapath. Call pushes PC+4; return pops the target.

Parameters:
- DEPTH, 8, number of stored entries (2..32, power of two not required).
- AW, 8, address/data width in bits.
- SP_TOP, 8'h00, stack-pointer value when empty; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  push request, sampled on rising clk.
- push_data  in  AW  address to store on push.
- pop  in  1  pop request, sampled on rising clk.
- pop_data  out  AW  registered popped address.
- pop_valid  out  1  one-cycle pulse; pop_data valid.
- sp  out  AW  current stack pointer (SP_TOP - 4*count, mod 2^AW).
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow_err  out  1  sticky: push attempted while full.
- underflow_err  out  1  sticky: pop attempted while empty.
- clear_err  in  1  synchronous clear of both sticky errors.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: count=0, sp=SP_TOP, pop_data=0, pop_valid=0, full=0, empty=1, both error flags 0. Storage contents are not reset.
- sp is a register updated with count, never derived combinationally from a multiply:
  - push: sp <= sp - 4.
  - pop: sp <= sp + 4.
  - All arithmetic is modulo 2^AW, so the 8'h00 -> 8'hFC wrap is legal.
- full and empty are combinational from count.
- Latency: pop_data/pop_valid are registered, one cycle after the pop edge. A push is visible to a pop on the next cycle.
- Per-cycle cases (priority as listed):
  - push only, not full: mem[count] <= push_data; count+1; sp-4.
  - push only, full: ignored; overflow_err <= 1; state unchanged.
  - pop only, not empty: pop_data <= mem[count-1]; pop_valid <= 1; count-1; sp+4.
  - pop only, empty: pop_valid stays 0; pop_data holds; underflow_err <= 1.
  - push+pop, not empty: replace top. pop_data <= old mem[count-1]; mem[count-1] <= push_data; pop_valid=1; count and sp unchanged. Legal even when full; no error.
  - push+pop, empty: bypass. pop_data <= push_data; pop_valid=1; count stays 0; no error.
  - neither: pop_valid <= 0; all else holds.
- Error flags:
  - clear_err takes effect next edge.
  - If clear_err and a new error occur in the same cycle, the new error wins (flag set).
- Reset mid-operation: asynchronous return to reset values immediately. A pending pop_valid pulse is dropped.

Optional Feature:
- Macro RAS_PEEK_EN.
- Defined: adds output peek_data [AW-1:0], driven combinationally with mem[count-1] when not empty, else 0. It reflects the stored state after each edge. This lets the fetch unit predict a return target without popping.
- Undefined: port and logic absent. Remaining behaviour is identical.

Test Plan:
- Reset, then push 8'h10, 8'h24, 8'h38:
  - count=3, sp=8'hF4.
  - Pops return 8'h38, 8'h24, 8'h10 on consecutive cycles, each with a pop_valid pulse.
  - Final sp=8'h00, empty=1.
- Fill to DEPTH=8, then push 8'hAA:
  - overflow_err=1; count stays 8; sp=8'hE0.
  - Next pop returns the 8th value, not 8'hAA.
  - clear_err -> overflow_err=0.
- Empty stack, pop -> underflow_err=1, pop_valid=0, sp=8'h00. Then push+pop together with 8'h5C -> pop_valid=1, pop_data=8'h5C, count=0.
- Stack holding 8'h40, push+pop with 8'h80 -> pop_data=8'h40, count unchanged. Next pop returns 8'h80.
- Push 8'h11 and 8'h22, assert rst_n low mid-cycle -> immediate count=0, sp=8'h00, empty=1, pop_valid=0 without waiting for a clock edge.
- With RAS_PEEK_EN, push 8'h7C -> peek_data=8'h7C next cycle. After a pop, peek_data=0.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack: push stores at mem[count] and moves sp down by 4; pop returns the top entry.
// Optional RAS_PEEK_EN adds a combinational peek_data port showing the top entry.
module ret_addr_stack #(
    parameter int             DEPTH  = 8,
    parameter int             AW     = 8,
    parameter logic [AW-1:0]  SP_TOP = '0,
    localparam int            CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] pop_data,
    output logic          pop_valid,
    output logic [AW-1:0] sp,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow_err,
    output logic          underflow_err,
`ifdef RAS_PEEK_EN
    output logic [AW-1:0] peek_data,
`endif
    input  logic          clear_err
);

    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [AW-1:0] pop_data_q, pop_data_d;
    logic          pop_valid_q, pop_valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          full_w, empty_w;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    // Only meaningful while not empty; every use below is guarded.
    assign top_idx = IW'(count_q - CW'(1));

    always_comb begin
        count_d     = count_q;
        sp_d        = sp_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = clear_err ? 1'b0 : ovf_q;
        unf_d       = clear_err ? 1'b0 : unf_q;
        wr_en       = 1'b0;
        wr_idx      = top_idx;

        unique case ({push, pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en   = 1'b1;
                    wr_idx  = IW'(count_q);
                    count_d = count_q + CW'(1);
                    sp_d    = sp_q - AW'(4);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_w) begin
                    pop_data_d  = mem_q[top_idx];
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CW'(1);
                    sp_d        = sp_q + AW'(4);
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (!empty_w) begin
                    // Replace top: return the old entry, overwrite it in place.
                    pop_data_d = mem_q[top_idx];
                    wr_en      = 1'b1;
                    wr_idx     = top_idx;
                end else begin
                    pop_data_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            sp_q        <= SP_TOP;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            sp_q        <= sp_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign pop_data      = pop_data_q;
    assign pop_valid     = pop_valid_q;
    assign sp            = sp_q;
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

`ifdef RAS_PEEK_EN
    assign peek_data = empty_w ? '0 : mem_q[top_idx];
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: directed scenarios then random traffic against a queue model.
module tb_ret_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [AW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          clear_err = 1'b0;
    logic [AW-1:0] pop_data;
    logic          pop_valid;
    logic [AW-1:0] sp;
    logic [CW-1:0] count;
    logic          full, empty, overflow_err, underflow_err;
`ifdef RAS_PEEK_EN
    logic [AW-1:0] peek_data;
`endif

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW), .SP_TOP(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp), .count(count),
        .full(full), .empty(empty), .overflow_err(overflow_err),
        .underflow_err(underflow_err),
`ifdef RAS_PEEK_EN
        .peek_data(peek_data),
`endif
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] m_pd = '0;
    bit         m_pv = 0, m_ovf = 0, m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pd = '0; m_pv = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit p, input logic [7:0] d, input bit q, input bit c);
        m_pv = 0;
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (p && q) begin
            m_pv = 1;
            if (mq.size() > 0) begin m_pd = mq[$]; mq[$] = d; end
            else m_pd = d;
        end else if (p) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1;
        end else if (q) begin
            if (mq.size() > 0) begin m_pd = mq.pop_back(); m_pv = 1; end
            else m_unf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_sp;
        e_sp = 8'(0 - 4 * mq.size());
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".sp"}, 32'(sp), 32'(e_sp));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
        chk({tag, ".pop_data"}, 32'(pop_data), 32'(m_pd));
        chk({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow_err), 32'(m_unf));
`ifdef RAS_PEEK_EN
        chk({tag, ".peek"}, 32'(peek_data), (mq.size() == 0) ? 32'h0 : 32'(mq[$]));
`endif
    endtask

    task automatic step(input string tag, input bit p, input logic [7:0] d, input bit q, input bit c);
        @(negedge clk);
        push = p; push_data = d; pop = q; clear_err = c;
        @(posedge clk);
        model_step(p, d, q, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] fill [8];
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk); rst_n = 1'b1;

        // Basic LIFO order
        step("push10", 1, 8'h10, 0, 0);
        step("push24", 1, 8'h24, 0, 0);
        step("push38", 1, 8'h38, 0, 0);
        chk("three.count", 32'(count), 32'd3);
        chk("three.sp", 32'(sp), 32'hF4);
        step("pop1", 0, 8'h00, 1, 0);
        chk("pop1.data", 32'(pop_data), 32'h38);
        step("pop2", 0, 8'h00, 1, 0);
        chk("pop2.data", 32'(pop_data), 32'h24);
        step("pop3", 0, 8'h00, 1, 0);
        chk("pop3.data", 32'(pop_data), 32'h10);
        chk("drained.sp", 32'(sp), 32'h00);
        chk("drained.empty", 32'(empty), 32'd1);
        step("idle", 0, 8'h00, 0, 0);

        // Fill, overflow, clear
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = 8'($urandom);
            step("fill", 1, fill[i], 0, 0);
        end
        step("ovf_push", 1, 8'hAA, 0, 0);
        chk("ovf.flag", 32'(overflow_err), 32'd1);
        chk("ovf.count", 32'(count), 32'd8);
        chk("ovf.sp", 32'(sp), 32'hE0);
        step("ovf_pop", 0, 8'h00, 1, 0);
        chk("ovf_pop.data", 32'(pop_data), 32'(fill[7]));
        step("ovf_clear", 0, 8'h00, 0, 1);
        chk("ovf_clear.flag", 32'(overflow_err), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 8'h00, 1, 0);

        // Underflow and empty bypass
        step("unf_pop", 0, 8'h00, 1, 0);
        chk("unf.flag", 32'(underflow_err), 32'd1);
        chk("unf.valid", 32'(pop_valid), 32'd0);
        chk("unf.sp", 32'(sp), 32'h00);
        step("bypass", 1, 8'h5C, 1, 0);
        chk("bypass.data", 32'(pop_data), 32'h5C);
        chk("bypass.valid", 32'(pop_valid), 32'd1);
        chk("bypass.count", 32'(count), 32'd0);
        step("clr_unf", 0, 8'h00, 0, 1);

        // Replace top
        step("push40", 1, 8'h40, 0, 0);
        step("replace", 1, 8'h80, 1, 0);
        chk("replace.data", 32'(pop_data), 32'h40);
        chk("replace.count", 32'(count), 32'd1);
        step("pop80", 0, 8'h00, 1, 0);
        chk("pop80.data", 32'(pop_data), 32'h80);

`ifdef RAS_PEEK_EN
        step("peek_push", 1, 8'h7C, 0, 0);
        chk("peek.val", 32'(peek_data), 32'h7C);
        step("peek_pop", 0, 8'h00, 1, 0);
        chk("peek.zero", 32'(peek_data), 32'h00);
`endif

        // Asynchronous reset mid-cycle with a pending pop_valid pulse
        step("r_push11", 1, 8'h11, 0, 0);
        step("r_push22", 1, 8'h22, 0, 0);
        step("r_pop", 0, 8'h00, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.sp", 32'(sp), 32'h00);
        chk("async_rst.valid", 32'(pop_valid), 32'd0);
        @(negedge clk);
        push = 0; pop = 0; clear_err = 0;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit p, q, c;
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 8);
            step("rand", p, 8'($urandom), q, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
